// File: rtl/crossing_scheduler_if.sv
// Signal bundle between the crossing scheduler and the lamp/button side of a pedestrian crossing.
// The slave modport is the scheduler; the master modport drives the button and watches the lamps.
interface crossing_scheduler_if;
    logic ped_req;
    logic ped_wait;
    logic p_rosu;
    logic p_verde;
    logic m_rosu;
    logic m_galben;
    logic m_verde;

    modport master (
        output ped_req,
        input  ped_wait,
        input  p_rosu,
        input  p_verde,
        input  m_rosu,
        input  m_galben,
        input  m_verde
    );

    modport slave (
        input  ped_req,
        output ped_wait,
        output p_rosu,
        output p_verde,
        output m_rosu,
        output m_galben,
        output m_verde
    );
endinterface

// File: rtl/crossing_scheduler.sv
// Pedestrian crossing lamp scheduler: six-state Moore controller with a shared 8-bit dwell timer.
// Optional build macro PED_FLASH_EN makes the pedestrian green flash (4 on / 4 off) during clearance.
module crossing_scheduler #(
    parameter int unsigned T_CAR_MIN = 20,
    parameter int unsigned T_YELLOW  = 3,
    parameter int unsigned T_ALLRED  = 2,
    parameter int unsigned T_PED     = 10,
    parameter int unsigned T_CLEAR   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    crossing_scheduler_if.slave   bus
);

    typedef enum logic [2:0] {
        CAR_GREEN  = 3'd0,
        CAR_YELLOW = 3'd1,
        ALL_RED1   = 3'd2,
        PED_GREEN  = 3'd3,
        PED_CLEAR  = 3'd4,
        ALL_RED2   = 3'd5
    } state_t;

    localparam logic [7:0] CAR_LAST    = 8'(T_CAR_MIN - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(T_YELLOW - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(T_ALLRED - 1);
    localparam logic [7:0] PED_LAST    = 8'(T_PED - 1);
    localparam logic [7:0] CLEAR_LAST  = 8'(T_CLEAR - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       req_q, req_d;
    logic       run_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAR_GREEN;
            timer_q <= 8'd0;
            req_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            req_q   <= req_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CAR_GREEN:  if (timer_q == CAR_LAST && req_q) state_d = CAR_YELLOW;
            CAR_YELLOW: if (timer_q == YELLOW_LAST)       state_d = ALL_RED1;
            ALL_RED1:   if (timer_q == ALLRED_LAST)       state_d = PED_GREEN;
            PED_GREEN:  if (timer_q == PED_LAST)          state_d = PED_CLEAR;
            PED_CLEAR:  if (timer_q == CLEAR_LAST)        state_d = ALL_RED2;
            ALL_RED2:   if (timer_q == ALLRED_LAST)       state_d = CAR_GREEN;
            default:                                      state_d = ALL_RED2;
        endcase
    end

    // Reset release is treated as the CAR_GREEN entry edge, so the first edge leaves the timer at 0.
    always_comb begin
        timer_d = timer_q + 8'd1;
        if (state_d != state_q || !run_q) begin
            timer_d = 8'd0;
        end else if (state_q == CAR_GREEN && timer_q == CAR_LAST) begin
            timer_d = timer_q;
        end
    end

    // Entering PED_GREEN serves the request; clearing wins over a simultaneous new press.
    always_comb begin
        req_d = req_q;
        if (state_d == PED_GREEN && state_q != PED_GREEN) begin
            req_d = 1'b0;
        end else if (bus.ped_req && (state_q inside {CAR_GREEN, CAR_YELLOW, ALL_RED1,
                                                     PED_CLEAR, ALL_RED2})) begin
            req_d = 1'b1;
        end
    end

    always_comb begin
        bus.m_rosu   = 1'b0;
        bus.m_galben = 1'b0;
        bus.m_verde  = 1'b0;
        bus.p_rosu   = 1'b0;
        bus.p_verde  = 1'b0;
        bus.ped_wait = req_q;
        case (state_q)
            CAR_GREEN: begin
                bus.m_verde = 1'b1;
                bus.p_rosu  = 1'b1;
            end
            CAR_YELLOW: begin
                bus.m_galben = 1'b1;
                bus.p_rosu   = 1'b1;
            end
            ALL_RED1, ALL_RED2: begin
                bus.m_rosu = 1'b1;
                bus.p_rosu = 1'b1;
            end
            PED_GREEN: begin
                bus.m_rosu  = 1'b1;
                bus.p_verde = 1'b1;
            end
            PED_CLEAR: begin
                bus.m_rosu  = 1'b1;
`ifdef PED_FLASH_EN
                bus.p_verde = ~timer_q[2];
`else
                bus.p_verde = 1'b1;
`endif
            end
            default: begin
                bus.m_rosu = 1'b1;
                bus.p_rosu = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_crossing_scheduler.sv
// Directed scoreboard bench for crossing_scheduler at default timing parameters.
// Lamp vector layout: {m_rosu, m_galben, m_verde, p_rosu, p_verde, ped_wait}.
module tb_crossing_scheduler;

    logic clk = 1'b0;
    logic rst_n;

    crossing_scheduler_if bus ();

    crossing_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] L_CG = 6'b001100;
    localparam logic [5:0] L_CY = 6'b010100;
    localparam logic [5:0] L_AR = 6'b100100;
    localparam logic [5:0] L_PG = 6'b100010;
    localparam logic [5:0] W    = 6'b000001;

    typedef struct {
        int         edge_n;
        logic [5:0] lamps;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ecount;

    function automatic logic [5:0] lamps();
        return {bus.m_rosu, bus.m_galben, bus.m_verde, bus.p_rosu, bus.p_verde, bus.ped_wait};
    endfunction

    // Expected clearance lamps for timer value k inside PED_CLEAR.
    function automatic logic [5:0] pc_lamps(input int k);
        logic [2:0] kb;
        kb = 3'(k);
`ifdef PED_FLASH_EN
        return kb[2] ? 6'b100000 : 6'b100010;
`else
        return 6'b100010;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic exp_at(input int e, input logic [5:0] l, input string tag);
        exp_t x;
        x.edge_n = e;
        x.lamps  = l;
        x.tag    = tag;
        sb.push_back(x);
    endtask

    task automatic check_edge(input int e);
        logic ok;
        exp_t x;
        ok = ($countones({bus.m_rosu, bus.m_galben, bus.m_verde}) == 1);
        chk($sformatf("car_onehot@%0d", e), {7'd0, ok}, 8'd1);
`ifdef PED_FLASH_EN
        ok = ($countones({bus.p_rosu, bus.p_verde}) <= 1);
`else
        ok = ($countones({bus.p_rosu, bus.p_verde}) == 1);
`endif
        chk($sformatf("ped_lamps@%0d", e), {7'd0, ok}, 8'd1);
        chk($sformatf("no_dual_green@%0d", e), {7'd0, bus.p_verde & bus.m_verde}, 8'd0);
        while (sb.size() > 0 && sb[0].edge_n <= e) begin
            x = sb.pop_front();
            chk($sformatf("%s@%0d", x.tag, x.edge_n), {2'b00, lamps()}, {2'b00, x.lamps});
        end
    endtask

    // Advance to the negedge following edge `target` (edges counted from reset release).
    task automatic run_to(input int target);
        while (ecount < target) begin
            @(posedge clk);
            ecount++;
            @(negedge clk);
            check_edge(ecount);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        ecount = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ped_req = 1'b0;
        rst_n       = 1'b0;
        ecount      = -1;
        #1;
        chk("reset_lamps", {2'b00, lamps()}, {2'b00, L_CG});
        chk("reset_timer", dut.timer_q, 8'd0);
        release_reset();

        // Idle: car green holds and the timer saturates at T_CAR_MIN-1.
        exp_at(0,  L_CG, "idle_start");
        exp_at(50, L_CG, "idle_mid");
        exp_at(99, L_CG, "idle_end");
        run_to(99);
        chk("idle_timer_sat", dut.timer_q, 8'd19);

        rst_n = 1'b0;
        #1;
        chk("reset2_lamps", {2'b00, lamps()}, {2'b00, L_CG});
        release_reset();

        // Early press, press during ALL_RED2, then a press held through PED_GREEN.
        exp_at(4,  L_CG,     "pre_press");
        exp_at(5,  L_CG | W, "press_latched");
        exp_at(19, L_CG | W, "green_min");
        exp_at(20, L_CY | W, "yellow_entry");
        exp_at(22, L_CY | W, "yellow_last");
        exp_at(23, L_AR | W, "allred1_entry");
        exp_at(24, L_AR | W, "allred1_last");
        exp_at(25, L_PG,     "pedgreen_entry");
        exp_at(34, L_PG,     "pedgreen_last");
        for (int k = 0; k < 8; k++) exp_at(35 + k, pc_lamps(k), "pedclear");
        exp_at(43, L_AR,     "allred2_entry");
        exp_at(44, L_AR | W, "allred2_press");
        exp_at(45, L_CG | W, "cargreen_return");
        exp_at(64, L_CG | W, "full_green_hold");
        exp_at(65, L_CY | W, "yellow_after_full_green");
        exp_at(68, L_AR | W, "allred1_b");
        exp_at(70, L_PG,     "pedgreen_b");
        exp_at(75, L_PG,     "pedgreen_held_req");
        exp_at(79, L_PG,     "pedgreen_b_last");
        exp_at(80, pc_lamps(0), "pedclear_b");
        exp_at(88, L_AR,     "allred2_b");
        exp_at(90, L_CG,     "cargreen_b");
        exp_at(120, L_CG,    "no_second_cycle");

        run_to(4);
        bus.ped_req = 1'b1;
        run_to(5);
        bus.ped_req = 1'b0;
        run_to(43);
        bus.ped_req = 1'b1;
        run_to(44);
        bus.ped_req = 1'b0;
        run_to(70);
        bus.ped_req = 1'b1;
        run_to(79);
        bus.ped_req = 1'b0;
        run_to(120);

        // Saturated timer: press at edge k gives yellow at k+1; then reset mid PED_GREEN.
        exp_at(121, L_CG | W, "sat_press");
        exp_at(122, L_CY | W, "sat_yellow_next_edge");
        exp_at(125, L_AR | W, "allred1_c");
        exp_at(127, L_PG,     "pedgreen_c");
        exp_at(130, L_PG,     "pedgreen_c_mid");
        bus.ped_req = 1'b1;
        run_to(121);
        bus.ped_req = 1'b0;
        run_to(130);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midcycle_reset_lamps", {2'b00, lamps()}, {2'b00, L_CG});
        chk("midcycle_reset_timer", dut.timer_q, 8'd0);
        release_reset();

        // Restart after reset; clearance lamp pattern checked cycle by cycle.
        exp_at(0,  L_CG | W, "restart_press");
        exp_at(19, L_CG | W, "restart_green_min");
        exp_at(20, L_CY | W, "restart_yellow");
        exp_at(23, L_AR | W, "restart_allred1");
        exp_at(25, L_PG,     "restart_pedgreen");
        for (int k = 0; k < 8; k++) exp_at(35 + k, pc_lamps(k), "restart_pedclear");
        exp_at(43, L_AR,     "restart_allred2");
        exp_at(45, L_CG,     "restart_cargreen");
        exp_at(50, L_CG,     "restart_idle");
        bus.ped_req = 1'b1;
        run_to(0);
        bus.ped_req = 1'b0;
        run_to(50);

        chk("scoreboard_drained", 8'(sb.size()), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/crossing_scheduler.md
CROSSING_SCHEDULER -- requirements
Module: crossing_scheduler

Interface
REQ-001 Parameter T_CAR_MIN, default 20, SHALL set the minimum car-green duration in cycles (legal 1..255).
REQ-002 Parameter T_YELLOW, default 3, SHALL set the car-yellow duration in cycles (legal 1..255).
REQ-003 Parameter T_ALLRED, default 2, SHALL set the duration of each all-red guard interval in cycles (legal 1..255).
REQ-004 Parameter T_PED, default 10, SHALL set the steady pedestrian-green duration in cycles (legal 1..255).
REQ-005 Parameter T_CLEAR, default 8, SHALL set the pedestrian-clearance duration in cycles (legal 1..255).
REQ-006 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-007 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-008 ped_req  input  1  SHALL be the pedestrian button, synchronous to clk, level-sampled.
REQ-009 ped_wait  output  1  SHALL mirror the latched request flag (the "WAIT" lamp).
REQ-010 p_rosu, p_verde  output  1 each  SHALL drive pedestrian red and green.
REQ-011 m_rosu, m_galben, m_verde  output  1 each  SHALL drive car red, yellow and green.

Function
REQ-012 States SHALL be CAR_GREEN, CAR_YELLOW, ALL_RED1, PED_GREEN, PED_CLEAR, ALL_RED2, cycling in that order.
REQ-013 An internal 8-bit timer SHALL clear to 0 on every state change and increment by 1 each cycle otherwise.
REQ-014 CAR_GREEN: the timer SHALL saturate at T_CAR_MIN-1 and never wrap.
REQ-015 CAR_GREEN SHALL exit to CAR_YELLOW on the edge where timer == T_CAR_MIN-1 and req_pending == 1; it SHALL not exit otherwise.
REQ-016 Every other state SHALL exit after exactly its parameter duration N (transition on the edge where timer == N-1).
REQ-017 req_pending SHALL set on any edge sampling ped_req == 1 in CAR_GREEN, CAR_YELLOW, ALL_RED1, PED_CLEAR or ALL_RED2.
REQ-018 req_pending SHALL clear on the edge entering PED_GREEN; ped_req during PED_GREEN SHALL be ignored.
REQ-019 A request latched during PED_CLEAR or ALL_RED2 SHALL be served only after a full T_CAR_MIN green.
REQ-020 With the timer saturated, ped_req sampled at edge k SHALL cause entry to CAR_YELLOW at edge k+1.
REQ-021 Outputs SHALL be Moore-decoded from the state register: CAR_GREEN {m_verde, p_rosu}; CAR_YELLOW {m_galben, p_rosu}; ALL_RED1/ALL_RED2 {m_rosu, p_rosu}; PED_GREEN/PED_CLEAR {m_rosu, p_verde}; all other lamps 0.
REQ-022 In every cycle exactly one car lamp and exactly one pedestrian lamp SHALL be on, except as allowed by REQ-027.
REQ-023 p_verde and m_verde SHALL never be 1 in the same cycle.
REQ-024 Unreachable state encodings SHALL recover to ALL_RED2 on the next edge, with all red lamps on meanwhile.

Reset
REQ-025 rst_n low SHALL immediately force state CAR_GREEN, timer 0 and req_pending 0, and hold them while low.
REQ-026 Reset values SHALL be: m_verde=1, p_rosu=1, m_rosu=0, m_galben=0, p_verde=0, ped_wait=0; assertion mid-cycle in any state SHALL abort the sequence with no glitch-filtering.

Configuration
REQ-027 With PED_FLASH_EN defined, p_verde in PED_CLEAR SHALL equal ~timer[2] (on 4 cycles, off 4 cycles, starting on), and p_rosu SHALL stay 0.
REQ-028 Without PED_FLASH_EN, p_verde SHALL be steady 1 throughout PED_CLEAR; all other behaviour SHALL be identical.

Verification (defaults; edge 0 = first rising edge after rst_n release)
REQ-029 No ped_req for 100 cycles -> m_verde=1 and p_rosu=1 throughout; timer holds at 19.
REQ-030 ped_req pulse at edge 5 -> ped_wait=1 after edge 5; CAR_YELLOW at edge 20, ALL_RED1 at 23, PED_GREEN at 25 (ped_wait=0), PED_CLEAR at 35, ALL_RED2 at 43, CAR_GREEN at 45.
REQ-031 ped_req at edge 60 with no earlier request -> CAR_YELLOW at edge 61.
REQ-032 ped_req held high through PED_GREEN, then released at PED_CLEAR entry -> ped_wait=0 during PED_GREEN and after return; no second pedestrian cycle.
REQ-033 ped_req pulse during ALL_RED2 -> ped_wait stays 1; the next CAR_YELLOW occurs exactly 20 cycles after CAR_GREEN entry.
REQ-034 rst_n low for 1 cycle during PED_GREEN -> outputs return to reset values asynchronously; ped_wait=0; the sequence restarts; with PED_FLASH_EN, p_verde pattern in PED_CLEAR = 1111 0000.
